// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind a UART receiver: edge-detects the frame-done strobe,
// buffers bytes, and hands them to a consumer one per accepted read.
module uart_rx_fifo #(
    parameter int SIZE_DATA = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx_done,
    input  logic [SIZE_DATA-1:0]   i_rx_data,
    output logic                   o_fifo_full,
    input  logic                   i_rd_en,
    output logic [SIZE_DATA-1:0]   o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_empty,
    output logic                   o_afull,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    input  logic                   i_clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

    logic [SIZE_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 rx_done_q;
    logic                 wr_evt;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 drop;
    logic [CW-1:0]        count_nxt;

    // Handshake: the write side has no backpressure beyond o_fifo_full (a rising
    // i_rx_done is one byte, dropped if there is no room); on the read side
    // i_rd_en is a request sampled every clock, accepted only when occupancy is
    // nonzero, and answered by a one-cycle o_rd_valid with o_rd_data on the next edge.
    assign wr_evt = i_rx_done & ~rx_done_q;
    assign rd_acc = i_rd_en & (o_count != '0);
    assign wr_acc = wr_evt & ((o_count != FULL_CNT) | rd_acc);
    assign drop   = wr_evt & ~wr_acc;

    always_comb begin
        count_nxt = o_count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = o_count + CW'(1);
            2'b01:   count_nxt = o_count - CW'(1);
            default: count_nxt = o_count;
        endcase
    end

    // Storage needs no reset; contents are only visible through accepted reads.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_done_q   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_empty     <= 1'b1;
            o_fifo_full <= 1'b0;
            o_afull     <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
            o_overflow  <= 1'b0;
        end else begin
            rx_done_q   <= i_rx_done;
            o_count     <= count_nxt;
            o_empty     <= (count_nxt == '0);
            o_fifo_full <= (count_nxt == FULL_CNT);
            o_afull     <= (count_nxt >= AFULL_CNT);
            o_rd_valid  <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // At full with a simultaneous write, wr_ptr == rd_ptr; the read
            // still sees the old (oldest) entry because the store is non-blocking.
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + AW'(1);
                o_rd_data <= mem[rd_ptr];
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected read bytes, a
// monitor pops and compares on every o_rd_valid.
module tb_uart_rx_fifo;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       o_fifo_full;
    logic       i_rd_en;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_empty;
    logic       o_afull;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       i_clr_ovf;

    logic [7:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;
    int         exp_cnt = 0;

    uart_rx_fifo dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .o_fifo_full (o_fifo_full),
        .i_rd_en     (i_rd_en),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_empty     (o_empty),
        .o_afull     (o_afull),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .i_clr_ovf   (i_clr_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid read must match the oldest outstanding expectation.
    always @(posedge i_clk) begin
        #1;
        if (i_rst_n && o_rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got valid data %0h expected no read at %0t", o_rd_data, $time);
            end else begin
                check("rd_data", {24'd0, o_rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_count"}, {27'd0, o_count}, exp_cnt);
        check({tag, "_empty"}, {31'd0, o_empty}, {31'd0, exp_cnt == 0});
        check({tag, "_full"},  {31'd0, o_fifo_full}, {31'd0, exp_cnt == 16});
        check({tag, "_afull"}, {31'd0, o_afull}, {31'd0, exp_cnt >= 12});
    endtask

    // One rising edge of i_rx_done followed by a low cycle.
    task automatic write_byte(input logic [7:0] d, input logic clr);
        i_rx_data = d;
        i_rx_done = 1'b1;
        i_clr_ovf = clr;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_clr_ovf = 1'b0;
        @(negedge i_clk);
        if (exp_cnt < 16) exp_cnt++;
    endtask

    task automatic read_byte(input logic [7:0] d, input logic expect_data);
        i_rd_en = 1'b1;
        if (expect_data) begin
            exp_q.push_back(d);
            exp_cnt--;
        end
        @(negedge i_clk);
        i_rd_en = 1'b0;
    endtask

    task automatic write_and_read(input logic [7:0] d, input logic [7:0] oldest, input logic expect_data);
        i_rx_data = d;
        i_rx_done = 1'b1;
        i_rd_en   = 1'b1;
        if (expect_data) exp_q.push_back(oldest);
        else exp_cnt++;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rd_en   = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},   {27'd0, o_count}, 0);
        check({tag, "_empty"},   {31'd0, o_empty}, 1);
        check({tag, "_full"},    {31'd0, o_fifo_full}, 0);
        check({tag, "_afull"},   {31'd0, o_afull}, 0);
        check({tag, "_valid"},   {31'd0, o_rd_valid}, 0);
        check({tag, "_rd_data"}, {24'd0, o_rd_data}, 0);
        check({tag, "_ovf"},     {31'd0, o_overflow}, 0);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_rd_en   = 1'b0;
        i_clr_ovf = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_values("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single byte round trip; o_rd_data then holds.
        write_byte(8'h29, 1'b0);
        check_flags("single_wr");
        read_byte(8'h29, 1'b1);
        check_flags("single_rd");
        repeat (3) @(negedge i_clk);
        check("rd_data_hold", {24'd0, o_rd_data}, 32'h29);

        // Level held high for 5 cycles is one write.
        i_rx_data = 8'hA5;
        i_rx_done = 1'b1;
        repeat (5) @(negedge i_clk);
        i_rx_done = 1'b0;
        @(negedge i_clk);
        exp_cnt = 1;
        check_flags("level");
        read_byte(8'hA5, 1'b1);
        @(negedge i_clk);

        // Fill, then drop with and without a simultaneous clear.
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i), 1'b0);
            check_flags("fill");
        end
        check("pre_drop_ovf", {31'd0, o_overflow}, 0);
        write_byte(8'hFF, 1'b0);
        check_flags("drop");
        check("drop_ovf", {31'd0, o_overflow}, 1);
        write_byte(8'hFE, 1'b1);
        check("drop_clr_ovf", {31'd0, o_overflow}, 1);
        i_clr_ovf = 1'b1;
        @(negedge i_clk);
        i_clr_ovf = 1'b0;
        check("clr_ovf", {31'd0, o_overflow}, 0);
        for (int i = 0; i < 16; i++) begin
            read_byte(8'(i), 1'b1);
        end
        @(negedge i_clk);
        check_flags("drain");

        // Simultaneous write and read at full.
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h10 + 8'(i), 1'b0);
        end
        write_and_read(8'h55, 8'h10, 1'b1);
        check_flags("sim_full");
        check("sim_full_ovf", {31'd0, o_overflow}, 0);
        for (int i = 1; i < 16; i++) begin
            read_byte(8'h10 + 8'(i), 1'b1);
        end
        read_byte(8'h55, 1'b1);
        @(negedge i_clk);
        check_flags("sim_drain");

        // Interleaved pairs wrap the pointers several times.
        for (int i = 0; i < 40; i++) begin
            write_byte(8'h80 + 8'(i), 1'b0);
            read_byte(8'h80 + 8'(i), 1'b1);
        end
        @(negedge i_clk);
        check_flags("wrap");

        // Read while empty is ignored, even with a write in the same cycle.
        read_byte(8'h00, 1'b0);
        @(negedge i_clk);
        check_flags("empty_rd");
        write_and_read(8'h3C, 8'h00, 1'b0);
        check_flags("empty_wr_rd");
        read_byte(8'h3C, 1'b1);
        @(negedge i_clk);
        check_flags("empty_wr_rd_drain");

        // Reset mid-operation with 5 bytes buffered and overflow set.
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h60 + 8'(i), 1'b0);
        end
        write_byte(8'hEE, 1'b0);
        for (int i = 0; i < 11; i++) begin
            read_byte(8'h60 + 8'(i), 1'b1);
        end
        @(negedge i_clk);
        check_flags("pre_rst");
        check("pre_rst_ovf", {31'd0, o_overflow}, 1);
        i_rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_cnt = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        read_byte(8'h00, 1'b0);
        @(negedge i_clk);
        check_flags("post_rst");

        // i_rx_done already high at reset release counts as a write.
        i_rst_n   = 1'b0;
        i_rx_data = 8'h77;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        exp_cnt = 1;
        check_flags("rel_high");
        read_byte(8'h77, 1'b1);
        @(negedge i_clk);
        check_flags("rel_high_drain");

        repeat (4) @(negedge i_clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter SIZE_DATA, default 8, SHALL set the width of a received UART data byte.
REQ-002 Parameter DEPTH, default 16, power of two, at least 2, SHALL set the number of FIFO entries.
REQ-003 Parameter AFULL_LVL, default 12, SHALL set the occupancy at and above which o_afull is asserted.
REQ-004 i_clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_rx_done  input  1  SHALL be the Receiver frame-done indication; its rising edge is the write event.
REQ-007 i_rx_data  input  SIZE_DATA  SHALL be the Receiver parallel byte, sampled on the same clock edge the write event is detected.
REQ-008 o_fifo_full  output  1  SHALL be the full flag, driven to the Receiver i_fifo_full.
REQ-009 i_rd_en  input  1  SHALL be the consumer read request; it is sampled every clock.
REQ-010 o_rd_data  output  SIZE_DATA  SHALL be the byte returned by an accepted read.
REQ-011 o_rd_valid  output  1  SHALL be a one-cycle pulse qualifying o_rd_data.
REQ-012 o_empty  output  1  SHALL be high when occupancy is 0.
REQ-013 o_afull  output  1  SHALL be high when occupancy is at least AFULL_LVL.
REQ-014 o_count  output  log2(DEPTH)+1  SHALL be the current occupancy, 0 to DEPTH.
REQ-015 o_overflow  output  1  SHALL be a sticky flag indicating at least one dropped byte.
REQ-016 i_clr_ovf  input  1  SHALL clear o_overflow synchronously.

Function
REQ-017 The block SHALL register i_rx_done and detect a write event when i_rx_done is 1 and the registered value is 0; a level held high for N cycles SHALL produce exactly one write.
REQ-018 A write event SHALL be accepted if occupancy is below DEPTH, or if a read is accepted in the same cycle. An accepted write stores i_rx_data at the write pointer and increments the write pointer modulo DEPTH.
REQ-019 A read SHALL be accepted when i_rd_en is 1 and occupancy is nonzero; a write arriving in the same cycle does not make an empty FIFO readable.
REQ-020 On an accepted read, the entry at the read pointer SHALL appear on o_rd_data on the next clock edge, with o_rd_valid high for exactly that one cycle. The read pointer SHALL increment modulo DEPTH.
REQ-021 o_rd_data SHALL hold its last value when no read is accepted.
REQ-022 A read while empty SHALL be ignored: no pointer change and no o_rd_valid.
REQ-023 Occupancy SHALL change as follows: +1 for a write only, -1 for a read only, unchanged for both or neither.
REQ-024 o_fifo_full, o_empty, o_afull and o_count SHALL be registered and consistent with occupancy after every edge.
REQ-025 A write event rejected because the FIFO is full with no accepted read SHALL be dropped, SHALL leave the FIFO contents and pointers unchanged, and SHALL set o_overflow on the next edge.
REQ-026 o_overflow SHALL stay high until i_clr_ovf is sampled high. If a drop and i_clr_ovf occur in the same cycle, o_overflow SHALL remain 1.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data.

Reset
REQ-028 While i_rst_n is 0, the following SHALL hold asynchronously: pointers 0, occupancy 0, o_count 0, o_empty 1, o_fifo_full 0, o_afull 0, o_rd_valid 0, o_rd_data 0, o_overflow 0, and the registered i_rx_done 0.
REQ-029 Storage array contents SHALL NOT require reset.
REQ-030 If reset is asserted mid-operation, all buffered bytes SHALL be discarded.
REQ-031 If i_rx_done is already high at reset release, that SHALL count as a write event on the first edge after release.

Verification
REQ-032 Single byte: i_rx_done rises with i_rx_data=8'h29, then i_rd_en pulses -> o_rd_data=8'h29 with o_rd_valid high one cycle later, o_empty returns to 1, o_count returns to 0.
REQ-033 Level hold: i_rx_done held high 5 cycles with data 8'hA5 -> o_count=1, not 5.
REQ-034 Fill and overflow: 16 writes of 8'h00 to 8'h0F -> o_fifo_full=1, o_afull=1 from the 12th write, o_count=16. A 17th write of 8'hFF -> dropped and o_overflow=1. Then 16 reads -> data 8'h00 to 8'h0F in order.
REQ-035 Simultaneous at full: write of 8'h55 in the same cycle as a read -> read returns the oldest byte, o_count stays 16, and 8'h55 is read last.
REQ-036 Wrap and empty read: 40 interleaved write/read pairs of incrementing data -> order preserved across wrap. A read while empty -> no o_rd_valid and o_count stays 0.
REQ-037 Reset mid-operation: with 5 bytes buffered and o_overflow=1, pulse i_rst_n low -> all REQ-028 values immediately, and the next read returns nothing.
